alu_issue_ctrl: RTL
===================

// Module: alu_issue_ctrl
// PURPOSE
//  Producer side of the ALU interface. Accepts one RV32I ALU instruction with its register operands.
//  Decodes it into the 4-bit ALU control code and drives the combinational ALU with registered operands.
//  Captures the ALU Result/Zero and presents them downstream with a valid/ready handshake.
//  Sits between the register-read stage and write-back.
// PARAMETERS
//  XLEN          32       data width of operands and result
//  ILLEGAL_CODE  4'b1111  control code driven for undecodable instructions (ALU returns 0)
// PORTS
//  clk           in   1     single clock, rising edge
//  rst_n         in   1     asynchronous, active-low reset
//  in_valid      in   1     instruction + operands valid
//  in_ready      out  1     block can accept (high only in IDLE)
//  instr         in   32    RV32I instruction word
//  rs1_data      in   XLEN  rs1 operand
//  rs2_data      in   XLEN  rs2 operand (R-type only)
//  alu_a         out  XLEN  to ALU A
//  alu_b         out  XLEN  to ALU B
//  alu_ctrl      out  4     to ALU ALUcontrol_In
//  alu_result    in   XLEN  from ALU Result
//  alu_zero      in   1     from ALU Zero
//  res_valid     out  1     result held and valid
//  res_ready     in   1     downstream accepts result
//  res_data      out  XLEN  captured ALU result
//  res_zero      out  1     captured Zero flag
//  res_illegal   out  1     instruction was not decodable
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE. alu_a=0, alu_b=0, alu_ctrl=4'b0000.
//    res_data=0, res_zero=0, res_illegal=0, res_valid=0, in_ready=1.
//  - FSM states:
//    IDLE: accept when in_valid&&in_ready; register decoded alu_a, alu_b, alu_ctrl, illegal flag; go to EXEC.
//    EXEC: operands stable for one full cycle; at its end capture alu_result/alu_zero; go to DONE.
//    DONE: res_valid=1, outputs stable; on res_ready go to IDLE (res_valid=0 next cycle).
//  - Latency: acceptance at edge T -> capture at edge T+1 -> res_valid high after edge T+1.
//    Minimum 3 cycles per instruction when res_ready is tied high.
//  - in_valid outside IDLE is ignored (no buffering); inputs are sampled only at acceptance.
//  - Decode codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100.
//    opcode 0110011 (R): a=rs1, b=rs2; f3=000 with f7=0000000 -> ADD, f7=0100000 -> SUB.
//      f3=111/110/100 -> AND/OR/XOR, which require f7=0000000.
//    opcode 0010011 (I): a=rs1, b=sign-extended instr[31:20]; f3=000/111/110/100 -> ADD/AND/OR/XOR.
//    Any other opcode/f3/f7 combination: alu_ctrl=ILLEGAL_CODE, a=b=0, res_illegal=1.
//      The flow proceeds normally, so res_data=0 and res_zero=1.
//  - alu_a/alu_b/alu_ctrl hold their last value in IDLE and DONE. No extra toggling.
//  - res_zero is captured from alu_zero, not recomputed.
//  - res_ready high while not in DONE has no effect. Acceptance is not allowed in DONE, even on the handshake cycle.
//  - Reset mid-operation discards the in-flight instruction; no result is produced.
// CONFIGURATION
//  ALU_LUI_EN defined: opcode 0110111 (LUI) decodes as ADD with a=0, b={instr[31:12],12'b0}, res_illegal=0.
//  ALU_LUI_EN undefined: LUI is illegal per the rule above.
// TESTING
//  1 reset: rst_n=0 mid-EXEC -> all outputs at reset values at once; in_ready=1 after release.
//  2 R ADD: rs1=5, rs2=7, f7=0, f3=000 -> alu_ctrl=0000; res_data=12, res_zero=0.
//    res_valid rises 2 edges after acceptance.
//  3 R SUB: rs1=rs2=32'h1234, f7=0100000 -> alu_ctrl=0001; res_data=0, res_zero=1.
//  4 I ADDI/XORI: rs1=10, imm=12'hFFF -> ADDI res_data=9; XORI res_data=32'hFFFFFFF5.
//  5 backpressure: res_ready=0 for 4 cycles in DONE -> res_* stable, in_ready=0.
//    in_valid ignored; one cycle after res_ready=1: res_valid=0, in_ready=1.
//  6 illegal: opcode 1100011 -> alu_ctrl=1111, res_illegal=1, res_data=0, res_zero=1.
//    LUI 32'h12345 with ALU_LUI_EN -> res_data=32'h12345000.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue controller for an RV32I ALU: decodes one instruction, drives the combinational ALU with registered
// operands, then holds the result behind a valid/ready handshake. Define ALU_LUI_EN to decode LUI as an ADD.
module alu_issue_ctrl #(
  parameter int          XLEN         = 32,
  parameter logic [3:0]  ILLEGAL_CODE = 4'b1111
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [XLEN-1:0] res_data,
  output logic            res_zero,
  output logic            res_illegal
);

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;

  localparam logic [3:0] CTRL_ADD = 4'b0000;
  localparam logic [3:0] CTRL_SUB = 4'b0001;
  localparam logic [3:0] CTRL_AND = 4'b0010;
  localparam logic [3:0] CTRL_OR  = 4'b0011;
  localparam logic [3:0] CTRL_XOR = 4'b0100;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t state, state_nxt;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [3:0]      dec_ctrl;
  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;
  logic            dec_ok;
  logic            accept;
  logic            illegal_q;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    dec_ctrl = ILLEGAL_CODE;
    dec_a    = '0;
    dec_b    = '0;
    dec_ok   = 1'b0;
    case (opcode)
      OPC_R: begin
        if (funct7 == 7'b0000000) begin
          dec_ok = 1'b1;
          case (funct3)
            3'b000:  dec_ctrl = CTRL_ADD;
            3'b111:  dec_ctrl = CTRL_AND;
            3'b110:  dec_ctrl = CTRL_OR;
            3'b100:  dec_ctrl = CTRL_XOR;
            default: dec_ok   = 1'b0;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec_ok   = 1'b1;
          dec_ctrl = CTRL_SUB;
        end
        if (dec_ok) begin
          dec_a = rs1_data;
          dec_b = rs2_data;
        end else begin
          dec_ctrl = ILLEGAL_CODE;
        end
      end
      OPC_I: begin
        dec_ok = 1'b1;
        case (funct3)
          3'b000:  dec_ctrl = CTRL_ADD;
          3'b111:  dec_ctrl = CTRL_AND;
          3'b110:  dec_ctrl = CTRL_OR;
          3'b100:  dec_ctrl = CTRL_XOR;
          default: dec_ok   = 1'b0;
        endcase
        if (dec_ok) begin
          dec_a = rs1_data;
          dec_b = XLEN'(signed'(instr[31:20]));
        end else begin
          dec_ctrl = ILLEGAL_CODE;
        end
      end
`ifdef ALU_LUI_EN
      OPC_LUI: begin
        dec_ok   = 1'b1;
        dec_ctrl = CTRL_ADD;
        dec_a    = '0;
        dec_b    = XLEN'({instr[31:12], 12'b0});
      end
`else
      OPC_LUI: ;  // treated like any other unknown opcode
`endif
      default: ;
    endcase
  end

  assign accept = (state == IDLE) && in_valid;

  // Handshake outputs follow the state directly; DONE only leaves on res_ready.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = EXEC;
      end
      EXEC: state_nxt = DONE;
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state elements use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operands change only on acceptance, so the ALU sees stable inputs through EXEC and DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_ctrl    <= 4'b0000;
      illegal_q   <= 1'b0;
      res_data    <= '0;
      res_zero    <= 1'b0;
      res_illegal <= 1'b0;
    end else begin
      if (accept) begin
        alu_a     <= dec_a;
        alu_b     <= dec_b;
        alu_ctrl  <= dec_ctrl;
        illegal_q <= !dec_ok;
      end
      if (state == EXEC) begin
        res_data    <= alu_result;
        res_zero    <= alu_zero;
        res_illegal <= illegal_q;
      end
    end
  end

endmodule
